// File: rtl/pipe_trace_emitter.sv
// Four-stage pipeline occupancy tracker (ID/EX/MEM/WB) that emits one trace
// record per retired-or-flushed instruction through a 4-entry FWFT FIFO.
module pipe_trace_emitter (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] if_pc,
  input  logic        trace_ready,
  output logic        trace_valid,
  output logic [7:0]  trace_id,
  output logic [15:0] trace_pc,
  output logic [15:0] trace_fetch_cycle,
  output logic [3:0]  trace_stalls,
  output logic        trace_flushed,
  output logic        overflow
);

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] pc;
    logic [15:0] fetch_cycle;
    logic [3:0]  stalls;
    logic        flushed;
  } rec_t;

  typedef struct packed {
    logic valid;
    rec_t rec;
  } slot_t;

  logic [15:0] r_cycle;
  logic [7:0]  r_next_id;
  slot_t       r_id, r_ex, r_mem, r_wb;

  rec_t        r_fifo [4];
  logic [1:0]  r_wr, r_rd;
  logic [2:0]  r_count;
  logic        r_overflow;

  logic        w_out_en, w_full, w_push, w_pop;
  rec_t        w_head;

  // Pipeline: stall freezes ID (counting stall cycles) and drops a bubble into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle   <= '0;
      r_next_id <= '0;
      r_id      <= '0;
      r_ex      <= '0;
      r_mem     <= '0;
      r_wb      <= '0;
    end else begin
      r_cycle <= r_cycle + 16'd1;
      if (!stall) begin
        r_id.valid            <= 1'b1;
        r_id.rec.id           <= r_next_id;
        r_id.rec.pc           <= if_pc;
        r_id.rec.fetch_cycle  <= r_cycle;
        r_id.rec.stalls       <= 4'd0;
        r_id.rec.flushed      <= flush;
        r_next_id             <= r_next_id + 8'd1;
        r_ex                  <= r_id;
      end else begin
        if (r_id.rec.stalls != 4'hF) r_id.rec.stalls <= r_id.rec.stalls + 4'd1;
        r_ex <= '0;
      end
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  // Handshake: a record transfers on any rising edge where trace_valid && trace_ready;
  // trace_valid never drops and the head never changes until that transfer happens.
  assign w_out_en = (r_count != 3'd0) && !rst;
  assign w_full   = (r_count == 3'd4);
  assign w_pop    = w_out_en && trace_ready;
  assign w_push   = r_wb.valid && (!w_full || w_pop);
  assign w_head   = r_fifo[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr] <= r_wb.rec;
        r_wr         <= r_wr + 2'd1;
      end
      if (w_pop) r_rd <= r_rd + 2'd1;
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      if (r_wb.valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign trace_valid       = w_out_en;
  assign trace_id          = w_out_en ? w_head.id          : 8'd0;
  assign trace_pc          = w_out_en ? w_head.pc          : 16'd0;
  assign trace_fetch_cycle = w_out_en ? w_head.fetch_cycle : 16'd0;
  assign trace_stalls      = w_out_en ? w_head.stalls      : 4'd0;
  assign trace_flushed     = w_out_en ? w_head.flushed     : 1'b0;
  assign overflow          = r_overflow && !rst;

endmodule

// File: tb/tb_pipe_trace_emitter.sv
// Directed bench for pipe_trace_emitter: per-test stimulus functions, an
// expected-record queue checked on every pop, and cycle-specific spot checks.
module tb_pipe_trace_emitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] if_pc = 16'd0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [7:0]  trace_id;
  logic [15:0] trace_pc;
  logic [15:0] trace_fetch_cycle;
  logic [3:0]  trace_stalls;
  logic        trace_flushed;
  logic        overflow;

  int          n_checks = 0;
  int          n_errors = 0;
  int          test_no  = 0;
  logic [15:0] pc_model = 16'd0;
  logic [44:0] exp_q[$];

  pipe_trace_emitter dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .if_pc(if_pc),
    .trace_ready(trace_ready), .trace_valid(trace_valid), .trace_id(trace_id),
    .trace_pc(trace_pc), .trace_fetch_cycle(trace_fetch_cycle),
    .trace_stalls(trace_stalls), .trace_flushed(trace_flushed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (test %0d): got 0x%0h expected 0x%0h", tag, test_no, obs, exp);
    end
  endtask

  task automatic push_rec(input int id, input int pc, input int fc, input int st, input int fl);
    exp_q.push_back({8'(id), 16'(pc), 16'(fc), 4'(st), 1'(fl)});
  endtask

  function automatic logic stall_f(input int c);
    case (test_no)
      2: return (c == 2 || c == 3);
      5: return (c >= 3 && c <= 22);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic flush_f(input int c);
    return (test_no == 3 || test_no == 5) && c == 3;
  endfunction

  function automatic logic ready_f(input int c);
    case (test_no)
      4: return c >= 13;
      6: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic reset_dut();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; if_pc = 16'd0; trace_ready = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(trace_valid), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_id", 64'(trace_id), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    pc_model = 16'd0;
    exp_q.delete();
  endtask

  task automatic spot(input int c);
    case (test_no)
      1: begin
        if (c == 4) check("t1_c4_valid", 64'(trace_valid), 64'(0));
        if (c == 5) begin
          check("t1_c5_valid", 64'(trace_valid), 64'(1));
          check("t1_c5_id", 64'(trace_id), 64'(0));
          check("t1_c5_pc", 64'(trace_pc), 64'(0));
          check("t1_c5_fc", 64'(trace_fetch_cycle), 64'(0));
          check("t1_c5_stalls", 64'(trace_stalls), 64'(0));
          check("t1_c5_flushed", 64'(trace_flushed), 64'(0));
        end
        if (c == 6) begin
          check("t1_c6_id", 64'(trace_id), 64'(1));
          check("t1_c6_pc", 64'(trace_pc), 64'(16'h0002));
          check("t1_c6_fc", 64'(trace_fetch_cycle), 64'(1));
        end
      end
      2: begin
        if (c == 6 || c == 7) check("t2_bubble", 64'(trace_valid), 64'(0));
        if (c == 8) check("t2_id1_stalls", 64'(trace_stalls), 64'(2));
        if (c == 9) begin
          check("t2_id2_pc", 64'(trace_pc), 64'(16'h0004));
          check("t2_id2_fc", 64'(trace_fetch_cycle), 64'(4));
        end
      end
      3: begin
        if (c == 8) begin
          check("t3_c8_id", 64'(trace_id), 64'(3));
          check("t3_c8_flushed", 64'(trace_flushed), 64'(1));
          check("t3_c8_pc", 64'(trace_pc), 64'(16'h0006));
        end
        if (c == 9) check("t3_c9_flushed", 64'(trace_flushed), 64'(0));
      end
      4: begin
        if (c == 8)  check("t4_c8_ovf", 64'(overflow), 64'(0));
        if (c == 9)  check("t4_c9_ovf", 64'(overflow), 64'(1));
        if (c == 12) check("t4_c12_valid", 64'(trace_valid), 64'(1));
        if (c == 17) check("t4_c17_id", 64'(trace_id), 64'(9));
        if (c == 21) check("t4_c21_ovf", 64'(overflow), 64'(1));
      end
      5: begin
        if (c == 27) begin
          check("t5_id", 64'(trace_id), 64'(2));
          check("t5_stalls", 64'(trace_stalls), 64'(15));
          check("t5_flushed", 64'(trace_flushed), 64'(0));
        end
      end
      6: begin
        if (c == 6) check("t6_buffered", 64'(trace_valid), 64'(1));
      end
      7: begin
        if (c == 0) begin
          check("t7_c0_valid", 64'(trace_valid), 64'(0));
          check("t7_c0_ovf", 64'(overflow), 64'(0));
        end
        if (c == 5) begin
          check("t7_c5_id", 64'(trace_id), 64'(0));
          check("t7_c5_fc", 64'(trace_fetch_cycle), 64'(0));
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input int c);
    logic [44:0] obs;
    logic [44:0] exp;
    stall = stall_f(c);
    flush = flush_f(c);
    trace_ready = ready_f(c);
    if_pc = pc_model;
    @(negedge clk);
    if (trace_valid && trace_ready) begin
      obs = {trace_id, trace_pc, trace_fetch_cycle, trace_stalls, trace_flushed};
      if (exp_q.size() == 0) begin
        check("extra_record", 64'(obs), 64'(0));
      end else begin
        exp = exp_q.pop_front();
        check("record", 64'(obs), 64'(exp));
      end
    end
    spot(c);
    @(posedge clk); #1;
    if (!stall) pc_model = pc_model + 16'd2;
  endtask

  task automatic run_cycles(input int ncyc);
    for (int c = 0; c < ncyc; c++) step(c);
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    // Straight-line flow.
    test_no = 1; reset_dut();
    for (int k = 0; k < 7; k++) push_rec(k, 2 * k, k, 0, 0);
    run_cycles(12);

    // Two-cycle stall while id 1 sits in ID; PC held during the stall.
    test_no = 2; reset_dut();
    push_rec(0, 0, 0, 0, 0);
    push_rec(1, 2, 1, 2, 0);
    push_rec(2, 4, 4, 0, 0);
    push_rec(3, 6, 5, 0, 0);
    push_rec(4, 8, 6, 0, 0);
    run_cycles(12);

    // Flush of the cycle-3 fetch.
    test_no = 3; reset_dut();
    for (int k = 0; k < 7; k++) push_rec(k, 2 * k, k, 0, (k == 3) ? 1 : 0);
    run_cycles(12);

    // Consumer blocked until cycle 13: ids 4..8 dropped.
    test_no = 4; reset_dut();
    for (int k = 0; k < 4; k++) push_rec(k, 2 * k, k, 0, 0);
    for (int k = 9; k < 14; k++) push_rec(k, 2 * k, k, 0, 0);
    run_cycles(22);

    // Stall and flush together, stall held 20 cycles.
    test_no = 5; reset_dut();
    push_rec(0, 0, 0, 0, 0);
    push_rec(1, 2, 1, 0, 0);
    push_rec(2, 4, 2, 15, 0);
    push_rec(3, 6, 23, 0, 0);
    run_cycles(29);

    // Mid-stream reset with three records buffered.
    test_no = 6; reset_dut();
    for (int c = 0; c < 7; c++) step(c);
    test_no = 7; reset_dut();
    push_rec(0, 0, 0, 0, 0);
    push_rec(1, 2, 1, 0, 0);
    run_cycles(7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
